// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants, chaining-state struct, FSM states and round helpers.
package sha1_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned ROUND_CNT = 80;
  localparam int unsigned CNT_W     = 7;
  localparam int unsigned BLOCK_W   = 512;
  localparam int unsigned DIGEST_W  = 160;
  localparam int unsigned WIN_WORDS = 16;

  typedef struct packed {
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic [WORD_W-1:0] c;
    logic [WORD_W-1:0] d;
    logic [WORD_W-1:0] e;
  } sha1_state_t;

  localparam sha1_state_t IV = '{a: 32'h67452301, b: 32'hEFCDAB89, c: 32'h98BADCFE,
                                 d: 32'h10325476, e: 32'hC3D2E1F0};

  localparam logic [WORD_W-1:0] K0 = 32'h5A827999;
  localparam logic [WORD_W-1:0] K1 = 32'h6ED9EBA1;
  localparam logic [WORD_W-1:0] K2 = 32'h8F1BBCDC;
  localparam logic [WORD_W-1:0] K3 = 32'hCA62C1D6;

  typedef enum logic [1:0] {IDLE, RUN, FIN, DONE} state_t;

  function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] x, input int unsigned s);
    return (x << s) | (x >> (WORD_W - s));
  endfunction

  // Round function chosen by 20-round phase: Ch, Parity, Maj, Parity.
  function automatic logic [WORD_W-1:0] f_sel(input logic [CNT_W-1:0] t,
                                              input logic [WORD_W-1:0] b,
                                              input logic [WORD_W-1:0] c,
                                              input logic [WORD_W-1:0] d);
    logic [WORD_W-1:0] f;
    f = b ^ c ^ d;
    if (t < CNT_W'(20))      f = (b & c) | (~b & d);
    else if (t < CNT_W'(40)) f = b ^ c ^ d;
    else if (t < CNT_W'(60)) f = (b & c) | (b & d) | (c & d);
    return f;
  endfunction

  function automatic logic [WORD_W-1:0] k_sel(input logic [CNT_W-1:0] t);
    logic [WORD_W-1:0] k;
    k = K3;
    if (t < CNT_W'(20))      k = K0;
    else if (t < CNT_W'(40)) k = K1;
    else if (t < CNT_W'(60)) k = K2;
    return k;
  endfunction

endpackage

// File: rtl/sha1_compress_if.sv
// Block-in / digest-out handshake bundle for the SHA-1 compression engine.
interface sha1_compress_if;
  import sha1_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [BLOCK_W-1:0]  in_block;
  logic                in_init;
  logic                out_valid;
  logic                out_ready;
  logic [DIGEST_W-1:0] out_digest;
  logic                busy;

  modport master (output in_valid, in_block, in_init, out_ready,
                  input  in_ready, out_valid, out_digest, busy);
  modport slave  (input  in_valid, in_block, in_init, out_ready,
                  output in_ready, out_valid, out_digest, busy);
endinterface

// File: rtl/sha1_step.sv
// One combinational SHA-1 round: {A,B,C,D,E}, W[t], t -> next {A,B,C,D,E}.
module sha1_step
  import sha1_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  sha1_state_t      st,
  input  logic [N-1:0]     w,
  input  logic [CNT_W-1:0] t,
  output sha1_state_t      st_next
);

  logic [N-1:0] temp;

  assign temp    = rotl(st.a, 5) + f_sel(t, st.b, st.c, st.d) + st.e + k_sel(t) + w;
  assign st_next = '{a: temp, b: st.a, c: rotl(st.b, 30), d: st.c, e: st.d};

endmodule

// File: rtl/sha1_compress.sv
// Iterative SHA-1 compression: RPC chained rounds per cycle, sliding 16-word schedule.
module sha1_compress
  import sha1_pkg::*;
#(
  parameter int unsigned RPC = 1,
  parameter int unsigned N   = 32
) (
  input logic            clk,
  input logic            rst_n,
  sha1_compress_if.slave bus
);

  typedef logic [0:WIN_WORDS-1][N-1:0] window_t;

  state_t           state, state_next;
  logic             in_ready_q, out_valid_q, busy_q;
  logic [CNT_W-1:0] cnt;
  logic             last_step;
  window_t          win, win_next;
  sha1_state_t      h, abcde, rounds_out;

  // Slide the window by RPC words; new words may depend on ones expanded this cycle.
  function automatic window_t next_window(input window_t cur);
    logic [N-1:0] e [WIN_WORDS+RPC];
    window_t      res;
    for (int i = 0; i < WIN_WORDS; i++) e[i] = cur[i];
    for (int k = 0; k < RPC; k++) e[WIN_WORDS+k] = rotl(e[k+13] ^ e[k+8] ^ e[k+2] ^ e[k], 1);
    for (int i = 0; i < WIN_WORDS; i++) res[i] = e[i+RPC];
    return res;
  endfunction

  assign win_next  = next_window(win);
  assign last_step = (cnt + CNT_W'(RPC)) == CNT_W'(ROUND_CNT);

  for (genvar j = 0; j < RPC; j++) begin : g_round
    sha1_state_t st_in, st_out;
    if (j == 0) begin : g_first
      assign st_in = abcde;
    end else begin : g_next
      assign st_in = g_round[j-1].st_out;
    end
    sha1_step #(.N(N)) u_step (
      .st      (st_in),
      .w       (win[j]),
      .t       (cnt + CNT_W'(j)),
      .st_next (st_out)
    );
  end

  assign rounds_out = g_round[RPC-1].st_out;

  always_comb begin : p_next_state
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_next = RUN;
      RUN:     if (last_step)     state_next = FIN;
      FIN:                        state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_state
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_next;
      in_ready_q  <= (state_next == IDLE);
      out_valid_q <= (state_next == DONE);
      busy_q      <= (state_next == RUN) || (state_next == FIN);
    end
  end

  // Working variables, schedule window, round counter and chaining value.
  always_ff @(posedge clk or negedge rst_n) begin : p_datapath
    if (!rst_n) begin
      h     <= IV;
      abcde <= '0;
      cnt   <= '0;
      win   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          win   <= window_t'(bus.in_block);
          if (bus.in_init) h <= IV;
          abcde <= bus.in_init ? IV : h;
          cnt   <= '0;
        end
        RUN: begin
          abcde <= rounds_out;
          win   <= win_next;
          cnt   <= cnt + CNT_W'(RPC);
        end
        FIN: h <= '{a: h.a + abcde.a, b: h.b + abcde.b, c: h.c + abcde.c,
                    d: h.d + abcde.d, e: h.e + abcde.e};
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = busy_q;
  assign bus.out_digest = h;

endmodule

// File: tb/tb_sha1_compress.sv
// Directed and model-checked bench for sha1_compress at RPC = 1, 4, 5, 16.
module tb_sha1_compress;

  localparam int ND = 4;

  localparam logic [159:0] IV_C     = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
  localparam logic [159:0] DIG_ABC  = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] DIG_EMP  = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
  localparam logic [159:0] DIG_2BLK = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

  localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMP = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_M1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_M2  = {480'h0, 32'h000001c0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         valid  [ND];
  logic         init   [ND];
  logic         oready [ND];
  logic [511:0] blk    [ND];
  wire          rdy    [ND];
  wire          ovalid [ND];
  wire          bsy    [ND];
  wire  [159:0] dig    [ND];
  logic [159:0] hm     [ND];

  int checks = 0;
  int failures = 0;

  function automatic int unsigned rpc_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 4 : (d == 2) ? 5 : 16;
  endfunction

  for (genvar g = 0; g < ND; g++) begin : g_dut
    sha1_compress_if ifc ();
    assign ifc.in_valid  = valid[g];
    assign ifc.in_block  = blk[g];
    assign ifc.in_init   = init[g];
    assign ifc.out_ready = oready[g];
    assign rdy[g]        = ifc.in_ready;
    assign ovalid[g]     = ifc.out_valid;
    assign bsy[g]        = ifc.busy;
    assign dig[g]        = ifc.out_digest;
    sha1_compress #(.RPC((g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 5 : 16), .N(32)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
    );
  end

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Straight textbook SHA-1 compression with a full 80-word schedule.
  function automatic logic [159:0] sha1_ref(input logic [159:0] hin, input logic [511:0] b);
    logic [31:0] w [80];
    logic [31:0] a, bb, c, dd, e, f, k, t, x;
    for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
    for (int i = 16; i < 80; i++) begin
      x = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {x[30:0], x[31]};
    end
    a = hin[159:128]; bb = hin[127:96]; c = hin[95:64]; dd = hin[63:32]; e = hin[31:0];
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (bb & c) | (~bb & dd);           k = 32'h5a827999; end
      else if (i < 40) begin f = bb ^ c ^ dd;                     k = 32'h6ed9eba1; end
      else if (i < 60) begin f = (bb & c) | (bb & dd) | (c & dd); k = 32'h8f1bbcdc; end
      else             begin f = bb ^ c ^ dd;                     k = 32'hca62c1d6; end
      t  = {a[26:0], a[31:27]} + f + e + k + w[i];
      e  = dd; dd = c; c = {bb[1:0], bb[31:2]}; bb = a; a = t;
    end
    return {hin[159:128] + a, hin[127:96] + bb, hin[95:64] + c, hin[63:32] + dd, hin[31:0] + e};
  endfunction

  // Present a block and return #1 after the accepting edge.
  task automatic send(input int d, input logic [511:0] b, input logic in_i);
    int n = 0;
    @(negedge clk);
    valid[d] = 1'b1; blk[d] = b; init[d] = in_i;
    while (!rdy[d] && n < 200) begin @(negedge clk); n++; end
    check("accept_ready", 160'(rdy[d]), 160'(1));
    @(posedge clk);
    #1 valid[d] = 1'b0;
  endtask

  // Count edges to out_valid, sample the digest, then complete the handshake after bp cycles.
  task automatic recv(input int d, input int bp, output logic [159:0] got, output int lat);
    lat = 0;
    while (!ovalid[d] && lat < 200) begin @(posedge clk); #1; lat++; end
    got = dig[d];
    repeat (bp) @(negedge clk);
    @(negedge clk); oready[d] = 1'b1;
    @(posedge clk); #1 oready[d] = 1'b0;
  endtask

  task automatic hash_check(input string tag, input int d, input logic [511:0] b,
                            input logic in_i, input logic [159:0] exp, input int bp);
    logic [159:0] got;
    int           lat;
    send(d, b, in_i);
    recv(d, bp, got, lat);
    check({tag, "_digest"}, got, exp);
    check({tag, "_latency"}, 160'(lat), 160'(80 / rpc_of(d) + 1));
    check({tag, "_ovalid_clr"}, 160'(ovalid[d]), 160'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    logic [159:0] got;
    logic [511:0] rb;
    logic         in_i;
    int           lat, n, nmsg;

    for (int i = 0; i < ND; i++) begin
      valid[i] = 1'b0; init[i] = 1'b0; oready[i] = 1'b0; blk[i] = '0; hm[i] = IV_C;
    end
    repeat (3) @(negedge clk);
    check("rst_in_ready", 160'(rdy[0]), 160'(1));
    check("rst_out_valid", 160'(ovalid[0]), 160'(0));
    check("rst_busy", 160'(bsy[0]), 160'(0));
    check("rst_digest_iv", dig[0], IV_C);
    rst_n = 1'b1;

    hash_check("abc", 0, BLK_ABC, 1'b1, DIG_ABC, 2);

    // out_ready held high before the digest appears is harmless.
    @(negedge clk); oready[0] = 1'b1;
    hash_check("empty", 0, BLK_EMP, 1'b1, DIG_EMP, 0);

    for (int d = 0; d < ND; d++) begin
      hash_check("two_blk1", d, BLK_M1, 1'b1, sha1_ref(IV_C, BLK_M1), 1);
      hash_check("two_blk2", d, BLK_M2, 1'b0, DIG_2BLK, 1);
    end

    // Mid-run status, ignored in_valid, and digest held under backpressure.
    send(0, BLK_ABC, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("run_in_ready", 160'(rdy[0]), 160'(0));
    check("run_busy", 160'(bsy[0]), 160'(1));
    check("run_out_valid", 160'(ovalid[0]), 160'(0));
    @(negedge clk); valid[0] = 1'b1; blk[0] = BLK_EMP; init[0] = 1'b1;
    repeat (3) @(negedge clk);
    valid[0] = 1'b0;
    n = 0;
    while (!ovalid[0] && n < 200) begin @(negedge clk); n++; end
    check("hold_digest0", dig[0], DIG_ABC);
    repeat (10) @(negedge clk);
    check("hold_out_valid", 160'(ovalid[0]), 160'(1));
    check("hold_digest10", dig[0], DIG_ABC);
    check("hold_busy", 160'(bsy[0]), 160'(0));
    oready[0] = 1'b1;
    @(posedge clk); #1 oready[0] = 1'b0;
    check("hold_release", 160'(ovalid[0]), 160'(0));
    check("idle_in_ready", 160'(rdy[0]), 160'(1));

    // Reset at cnt=40 restores IV, so an unchained "abc" gives the IV-based digest.
    send(0, BLK_EMP, 1'b1);
    repeat (40) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_in_ready", 160'(rdy[0]), 160'(1));
    check("abort_out_valid", 160'(ovalid[0]), 160'(0));
    check("abort_busy", 160'(bsy[0]), 160'(0));
    check("abort_digest_iv", dig[0], IV_C);
    @(negedge clk); rst_n = 1'b1;
    hash_check("abc_after_abort", 0, BLK_ABC, 1'b0, DIG_ABC, 0);

    for (int d = 0; d < ND; d++) begin
      nmsg = (d == 0) ? 20 : 80;
      for (int m = 0; m < nmsg; m++) begin
        for (int i = 0; i < 16; i++) rb[32*i +: 32] = $urandom();
        in_i = (m == 0) || ($urandom_range(0, 3) == 0);
        hm[d] = sha1_ref(in_i ? IV_C : hm[d], rb);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send(d, rb, in_i);
        recv(d, int'($urandom_range(0, 4)), got, lat);
        check("rand_digest", got, hm[d]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
